// File: rtl/imu_rd_seq_pkg.sv
// rtl/imu_rd_seq_pkg.sv - shared state type and SPI command words for the IMU read sequencer
package imu_rd_seq_pkg;

  typedef enum logic [2:0] {
    STARTUP,
    CFG_WR,
    CFG_WAIT,
    IDLE,
    RD_WR,
    RD_WAIT,
    VALID
  } state_t;

  localparam logic [1:0] CFG_LAST = 2'd3;
  localparam logic [2:0] RD_LAST  = 3'd5;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1160;
      2'd2:    return 16'h1050;
      default: return 16'h1460;
    endcase
  endfunction

  // Gyro rate registers: pitch lo/hi, roll lo/hi, yaw lo/hi.
  function automatic logic [15:0] rd_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'hA2FF;
      3'd1:    return 16'hA3FF;
      3'd2:    return 16'hA4FF;
      3'd3:    return 16'hA5FF;
      3'd4:    return 16'hA6FF;
      3'd5:    return 16'hA7FF;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/imu_rd_seq.sv
// rtl/imu_rd_seq.sv - IMU startup config writer and gyro-rate burst reader driving SPI_mnrch
module imu_rd_seq
  import imu_rd_seq_pkg::*;
#(
  parameter logic [15:0] STARTUP_CYC = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic               wrt,
  output logic [15:0]        wt_data,
  output logic               init_done,
  output logic               vld,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] roll_rt,
  output logic signed [15:0] yaw_rt
);

  state_t      state, nxt;
  logic [15:0] timer, timer_nxt;
  logic [1:0]  cfg_idx, cfg_nxt;
  logic [2:0]  rd_idx, rd_nxt;
  logic        INT_ff1, INT_ff2;
  logic [7:0]  stg [6];
  logic        wrt_nxt, init_nxt, cap, load;
  logic [15:0] wt_nxt;

  always_comb begin
    nxt       = state;
    timer_nxt = timer;
    cfg_nxt   = cfg_idx;
    rd_nxt    = rd_idx;
    init_nxt  = init_done;
    wrt_nxt   = 1'b0;
    wt_nxt    = wt_data;
    cap       = 1'b0;
    load      = 1'b0;
    case (state)
      STARTUP:
        if (timer == STARTUP_CYC - 16'd1) begin
          nxt     = CFG_WR;
          cfg_nxt = 2'd0;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      CFG_WR:   nxt = CFG_WAIT;
      CFG_WAIT:
        if (done) begin
          if (cfg_idx == CFG_LAST) begin
            nxt      = IDLE;
            init_nxt = 1'b1;
          end else begin
            cfg_nxt = cfg_idx + 2'd1;
            nxt     = CFG_WR;
          end
        end
      IDLE:
        if (INT_ff2) begin
          nxt    = RD_WR;
          rd_nxt = 3'd0;
        end
      RD_WR:    nxt = RD_WAIT;
      RD_WAIT:
        if (done) begin
          cap = 1'b1;
          if (rd_idx == RD_LAST) begin
            nxt = VALID;
          end else begin
            rd_nxt = rd_idx + 3'd1;
            nxt    = RD_WR;
          end
        end
      VALID: begin
        nxt  = IDLE;
        load = 1'b1;
      end
      default:  nxt = STARTUP;
    endcase
    // wrt/wt_data are registered, so they are set up on the edge that enters a *_WR state.
    if (nxt == CFG_WR) begin
      wrt_nxt = 1'b1;
      wt_nxt  = cfg_word(cfg_nxt);
    end else if (nxt == RD_WR) begin
      wrt_nxt = 1'b1;
      wt_nxt  = rd_word(rd_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STARTUP;
      timer     <= 16'd0;
      cfg_idx   <= 2'd0;
      rd_idx    <= 3'd0;
      INT_ff1   <= 1'b0;
      INT_ff2   <= 1'b0;
      wrt       <= 1'b0;
      wt_data   <= 16'd0;
      init_done <= 1'b0;
      vld       <= 1'b0;
      ptch_rt   <= '0;
      roll_rt   <= '0;
      yaw_rt    <= '0;
      for (int i = 0; i < 6; i++) stg[i] <= 8'd0;
    end else begin
      state     <= nxt;
      timer     <= timer_nxt;
      cfg_idx   <= cfg_nxt;
      rd_idx    <= rd_nxt;
      INT_ff1   <= INT;
      INT_ff2   <= INT_ff1;
      wrt       <= wrt_nxt;
      wt_data   <= wt_nxt;
      init_done <= init_nxt;
      vld       <= load;
      for (int i = 0; i < 6; i++)
        if (cap && rd_idx == 3'(i)) stg[i] <= rd_data[7:0];
      // All three rates move together with vld so a partial burst is never observable.
      if (load) begin
        ptch_rt <= {stg[1], stg[0]};
        roll_rt <= {stg[3], stg[2]};
        yaw_rt  <= {stg[5], stg[4]};
      end
    end
  end

endmodule

// File: tb/tb_imu_rd_seq.sv
// tb/tb_imu_rd_seq.sv - directed self-checking bench for imu_rd_seq with SPI/IMU model
module tb_imu_rd_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               INT;
  logic               done = 1'b1;
  logic [15:0]        rd_data = 16'd0;
  logic               wrt;
  logic [15:0]        wt_data;
  logic               init_done;
  logic               vld;
  logic signed [15:0] ptch_rt, roll_rt, yaw_rt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  imu_reg [8];
  int          spi_cnt  = 0;
  logic [15:0] spi_word = 16'd0;

  logic [15:0] cfg_tbl [4] = '{16'h0D02, 16'h1160, 16'h1050, 16'h1460};
  logic [15:0] rd_tbl  [6] = '{16'hA2FF, 16'hA3FF, 16'hA4FF, 16'hA5FF, 16'hA6FF, 16'hA7FF};

  imu_rd_seq #(.STARTUP_CYC(16'd16)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .wt_data(wt_data), .init_done(init_done), .vld(vld),
    .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt)
  );

  always #5 clk = ~clk;

  // SPI_mnrch + IMU serf: done stays high until the cycle after wrt, then returns after 4 cycles.
  always @(posedge clk) begin
    if (wrt) begin
      done     <= 1'b0;
      spi_cnt  <= 4;
      spi_word <= wt_data;
    end else if (spi_cnt > 0) begin
      spi_cnt <= spi_cnt - 1;
      if (spi_cnt == 1) begin
        done    <= 1'b1;
        rd_data <= {8'h00, imu_reg[spi_word[10:8]]};
      end
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_wrt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (wrt) ok = 1'b1;
    end
  endtask

  task automatic startup_cfg();
    int early;
    bit ok;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wrt) early++;
    end
    check_eq("startup_early_wrt", 16'(early), 16'd0);
    @(negedge clk);
    check_eq("startup_wrt_at_16", 16'(wrt), 16'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        wait_wrt(ok);
        check_eq("cfg_wrt_seen", 16'(ok), 16'd1);
      end
      check_eq("cfg_word", wt_data, cfg_tbl[k]);
      check_eq("init_done_early", 16'(init_done), 16'd0);
    end
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (init_done) ok = 1'b1;
    end
    check_eq("init_done_set", 16'(ok), 16'd1);
  endtask

  task automatic do_burst(input logic [15:0] ep, input logic [15:0] er, input logic [15:0] ey);
    int          nwrt;
    bit          got, moved;
    logic [15:0] p0, r0, y0;
    nwrt  = 0;
    got   = 1'b0;
    moved = 1'b0;
    p0 = ptch_rt; r0 = roll_rt; y0 = yaw_rt;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (vld) begin
        got = 1'b1;
      end else begin
        if (ptch_rt !== p0 || roll_rt !== r0 || yaw_rt !== y0) moved = 1'b1;
        if (wrt) begin
          if (nwrt < 6) check_eq("rd_cmd", wt_data, rd_tbl[nwrt]);
          nwrt++;
        end
      end
    end
    check_eq("vld_seen", 16'(got), 16'd1);
    check_eq("wrt_per_burst", 16'(nwrt), 16'd6);
    check_eq("partial_visible", 16'(moved), 16'd0);
    check_eq("wrt_in_vld_cycle", 16'(wrt), 16'd0);
    check_eq("ptch_rt", ptch_rt, ep);
    check_eq("roll_rt", roll_rt, er);
    check_eq("yaw_rt", yaw_rt, ey);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  ok;
    imu_reg[0] = 8'h00; imu_reg[1] = 8'h00;
    imu_reg[2] = 8'h34; imu_reg[3] = 8'h12;
    imu_reg[4] = 8'h78; imu_reg[5] = 8'h56;
    imu_reg[6] = 8'hCD; imu_reg[7] = 8'hAB;
    rst = 1'b1;
    INT = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wrt", 16'(wrt), 16'd0);
    check_eq("rst_wt_data", wt_data, 16'd0);
    check_eq("rst_init_done", 16'(init_done), 16'd0);
    check_eq("rst_vld", 16'(vld), 16'd0);
    check_eq("rst_ptch", ptch_rt, 16'd0);
    check_eq("rst_roll", roll_rt, 16'd0);
    check_eq("rst_yaw", yaw_rt, 16'd0);

    rst = 1'b0;
    startup_cfg();

    // Single INT pulse: exactly one burst, then quiet.
    @(negedge clk); INT = 1'b1;
    @(negedge clk); @(negedge clk); INT = 1'b0;
    do_burst(16'h1234, 16'h5678, 16'hABCD);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (vld || wrt) cnt++;
    end
    check_eq("single_int_one_burst", 16'(cnt), 16'd0);

    // INT held high: back-to-back bursts, each a full 6 reads.
    imu_reg[2] = 8'h01; imu_reg[3] = 8'h80;
    imu_reg[4] = 8'hFF; imu_reg[5] = 8'h7F;
    imu_reg[6] = 8'h00; imu_reg[7] = 8'h00;
    INT = 1'b1;
    do_burst(16'h8001, 16'h7FFF, 16'h0000);
    do_burst(16'h8001, 16'h7FFF, 16'h0000);
    INT = 1'b0;
    do_burst(16'h8001, 16'h7FFF, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (vld || wrt) cnt++;
    end
    check_eq("held_int_drain", 16'(cnt), 16'd0);

    // Reset during the 3rd read of a burst.
    imu_reg[2] = 8'h34; imu_reg[3] = 8'h12;
    imu_reg[4] = 8'h78; imu_reg[5] = 8'h56;
    imu_reg[6] = 8'hCD; imu_reg[7] = 8'hAB;
    do_burst_prime();
    for (int k = 0; k < 3; k++) begin
      wait_wrt(ok);
      check_eq("pre_rst_wrt_seen", 16'(ok), 16'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("abort_wrt", 16'(wrt), 16'd0);
    check_eq("abort_init_done", 16'(init_done), 16'd0);
    check_eq("abort_ptch", ptch_rt, 16'd0);
    check_eq("abort_roll", roll_rt, 16'd0);
    check_eq("abort_yaw", yaw_rt, 16'd0);
    check_eq("abort_wt_data", wt_data, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    startup_cfg();
    check_eq("post_cfg_ptch", ptch_rt, 16'd0);
    check_eq("post_cfg_yaw", yaw_rt, 16'd0);
    imu_reg[2] = 8'h21; imu_reg[3] = 8'h43;
    imu_reg[4] = 8'h65; imu_reg[5] = 8'h87;
    imu_reg[6] = 8'h09; imu_reg[7] = 8'hBA;
    @(negedge clk); INT = 1'b1;
    @(negedge clk); @(negedge clk); INT = 1'b0;
    do_burst(16'h4321, 16'h8765, 16'hBA09);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic do_burst_prime();
    @(negedge clk); INT = 1'b1;
    @(negedge clk); @(negedge clk); INT = 1'b0;
  endtask

endmodule

// File: doc/imu_rd_seq.md
IMU_RD_SEQ -- requirements
Module: imu_rd_seq

Interface
REQ-001 SHALL have parameter STARTUP_CYC, default 16'hFFFF, meaning clk cycles to wait after reset before the first config write.
REQ-002 SHALL have port clk  input  1  system clock, all flops on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port INT  input  1  IMU data-ready, asynchronous to clk.
REQ-005 SHALL have port done  input  1  SPI transaction complete (level, from SPI_mnrch).
REQ-006 SHALL have port rd_data  input  16  SPI read word (from SPI_mnrch).
REQ-007 SHALL have port wrt  output  1  one-cycle SPI start pulse.
REQ-008 SHALL have port wt_data  output  16  SPI command word, {cmd[7:0], data[7:0]}.
REQ-009 SHALL have port init_done  output  1  config sequence complete.
REQ-010 SHALL have port vld  output  1  one-cycle pulse, new rate sample ready.
REQ-011 SHALL have ports ptch_rt, roll_rt, yaw_rt  output  16 each  signed gyro rates.

Function
REQ-012 SHALL double-flop INT into INT_ff2 (reset 0); only INT_ff2 is used by the FSM.
REQ-013 SHALL implement states STARTUP, CFG_WR, CFG_WAIT, IDLE, RD_WR, RD_WAIT, VALID.
REQ-014 STARTUP: 16-bit timer counts from 0; at count == STARTUP_CYC-1 -> CFG_WR, cfg index = 0.
REQ-015 Config words by index: 0:16'h0D02, 1:16'h1160, 2:16'h1050, 3:16'h1460.
REQ-016 CFG_WR: wrt=1 for exactly one cycle, wt_data = word[index] -> CFG_WAIT.
REQ-017 CFG_WAIT: on done=1, if index==3 -> IDLE and set init_done, else index+1 -> CFG_WR.
REQ-018 done is low on the cycle after wrt; FSM SHALL advance only on done=1 seen in a *_WAIT state, never in the wrt cycle.
REQ-019 IDLE: if INT_ff2=1 -> RD_WR, rd index = 0; else stay.
REQ-020 Read words by index: 0:16'hA2FF, 1:16'hA3FF, 2:16'hA4FF, 3:16'hA5FF, 4:16'hA6FF, 5:16'hA7FF.
REQ-021 RD_WR: wrt one cycle, wt_data = read word[index] -> RD_WAIT.
REQ-022 RD_WAIT: on done=1 capture rd_data[7:0] into staging byte[index]; index==5 -> VALID, else index+1 -> RD_WR.
REQ-023 VALID: load ptch_rt={byte1,byte0}, roll_rt={byte3,byte2}, yaw_rt={byte5,byte4} in the same edge; vld=1 that cycle -> IDLE.
REQ-024 Outputs SHALL change only on the VALID update; partial reads never visible.
REQ-025 INT_ff2 while not in IDLE SHALL be ignored; re-sampled on return to IDLE (no queuing).
REQ-026 wt_data SHALL hold its last value outside CFG_WR/RD_WR; wrt=0 in all other states.
REQ-027 Indices SHALL not wrap: cfg index max 3, rd index max 5, reset to 0 on entry to the sequence.

Reset
REQ-028 On rst=1: state STARTUP, timer 0, indices 0, wrt 0, wt_data 0, init_done 0, vld 0, rate outputs 0, staging 0, INT flops 0.
REQ-029 rst asserted mid-transaction SHALL abort immediately; after release the full STARTUP/config sequence reruns.

Structure
REQ-030 Shared package SHALL hold the state typedef and the config/read command word constants.
REQ-031 SHALL be one module with no sub-modules; intended to pair with SPI_mnrch (wrt/wt_data/done/rd_data wired directly).

Verification
REQ-032 Bench SHALL use an SPI_mnrch + IMU serf model with STARTUP_CYC overridden to 16.
REQ-033 Release rst -> first wrt after 16 cycles; wt_data sequence 0D02, 1160, 1050, 1460; init_done=1 after 4th done.
REQ-034 IMU regs A2..A7 = 34,12,78,56,CD,AB; pulse INT -> vld once, ptch_rt=16'h1234, roll_rt=16'h5678, yaw_rt=16'hABCD.
REQ-035 Hold INT high through read -> exactly one read burst per IDLE visit, back-to-back bursts separated by >=1 IDLE cycle.
REQ-036 Hold done high from previous transfer across wrt -> no state advance in the wrt cycle; exactly 6 wrt per burst.
REQ-037 Assert rst during 3rd read -> wrt=0, outputs 0, init_done=0 at once; after release config reruns and old rates never appear.
